// File: rtl/ts_defs_pkg.sv
// ts_defs: shared constants and FSM state type for the TS sync detector.
//   TS_PKT_LEN    standard MPEG-2 TS packet length in bytes
//   TS_SYNC_BYTE  TS sync byte value
//   ts_state_e    detector FSM states (HUNT / VERIFY / LOCKED)
package ts_defs;

    localparam int unsigned TS_PKT_LEN   = 188;
    localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } ts_state_e;

endpackage

// File: rtl/ts_pos_counter.sv
// ts_pos_counter: byte position within a TS packet.
//   clk      clock, posedge
//   rst_n    synchronous reset, active-low (pos -> 0)
//   en       advance by one, wrapping PKT_LEN-1 -> 0
//   clr      force pos to 0 (highest priority after reset)
//   load1    force pos to 1 (a sync byte was just taken as position 0)
//   pos      current position
//   at_zero  pos == 0 (packet boundary)
//   at_last  pos == PKT_LEN-1
module ts_pos_counter #(
    parameter int unsigned PKT_LEN = 188,
    parameter int unsigned POS_W   = $clog2(PKT_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load1,
    output logic [POS_W-1:0] pos,
    output logic             at_zero,
    output logic             at_last
);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(PKT_LEN - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos <= '0;
        end else if (clr) begin
            pos <= '0;
        end else if (load1) begin
            pos <= POS_W'(1);
        end else if (en) begin
            pos <= (pos == POS_LAST) ? '0 : pos + 1'b1;
        end
    end

    assign at_zero = (pos == '0);
    assign at_last = (pos == POS_LAST);

endmodule

// File: rtl/ts_sync_detector.sv
// ts_sync_detector: per-stream MPEG-2 TS packet synchronizer.
// Hunts for SYNC_BYTE repeated every PKT_LEN bytes, locks after LOCK_CNT
// correctly spaced syncs, drops lock after UNLOCK_CNT consecutive misses,
// and forwards only whole, aligned packets with a fixed 1-cycle latency.
//   clk, rst_n              clock / synchronous active-low reset
//   in_valid, in_data       input byte stream (gaps allowed)
//   out_valid, out_data     aligned output bytes
//   out_sop, out_eop        first / last byte of a forwarded packet
//   out_sync_err            with out_sop: byte 0 was not SYNC_BYTE while locked
//   locked                  FSM is in LOCKED
//   sync_loss               one-cycle pulse on LOCKED -> HUNT
//   loss_count              saturating count of sync_loss events
//   pkt_count               wrapping count of forwarded packets
module ts_sync_detector
    import ts_defs::*;
#(
    parameter int unsigned          DATA_WIDTH = 8,
    parameter int unsigned          PKT_LEN    = TS_PKT_LEN,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE = DATA_WIDTH'(TS_SYNC_BYTE),
    parameter int unsigned          LOCK_CNT   = 3,
    parameter int unsigned          UNLOCK_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  out_sync_err,
    output logic                  locked,
    output logic                  sync_loss,
    output logic [15:0]           loss_count,
    output logic [31:0]           pkt_count
);

    localparam int unsigned POS_W  = $clog2(PKT_LEN);
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W = $clog2(UNLOCK_CNT + 1);
    // Counter values at which one more event completes lock / loss.
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_CNT - 1);

    ts_state_e         state, state_nxt;
    logic [GOOD_W-1:0] good, good_nxt;
    logic [MISS_W-1:0] miss, miss_nxt;

    logic [POS_W-1:0]  pos;
    logic              at_zero, at_last;
    logic              pos_en, pos_clr, pos_load1;
    logic              is_sync;
    logic              fwd;
    logic              lose;

    ts_pos_counter #(
        .PKT_LEN (PKT_LEN),
        .POS_W   (POS_W)
    ) u_pos (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (pos_en),
        .clr     (pos_clr),
        .load1   (pos_load1),
        .pos     (pos),
        .at_zero (at_zero),
        .at_last (at_last)
    );

    assign is_sync = (in_data == SYNC_BYTE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_HUNT;
            good  <= '0;
            miss  <= '0;
        end else begin
            state <= state_nxt;
            good  <= good_nxt;
            miss  <= miss_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        miss_nxt  = miss;
        pos_en    = 1'b0;
        pos_clr   = 1'b0;
        pos_load1 = 1'b0;
        fwd       = 1'b0;
        lose      = 1'b0;
        if (in_valid) begin
            unique case (state)
                ST_HUNT: begin
                    if (is_sync) begin
                        state_nxt = ST_VERIFY;
                        pos_load1 = 1'b1;
                        good_nxt  = GOOD_W'(1);
                    end
                end
                ST_VERIFY: begin
                    pos_en = 1'b1;
                    if (at_zero) begin
                        if (!is_sync) begin
                            state_nxt = ST_HUNT;
                            good_nxt  = '0;
                            pos_clr   = 1'b1;
                        end else if (good == GOOD_LAST) begin
                            // The locking sync byte itself opens the first output packet.
                            state_nxt = ST_LOCKED;
                            good_nxt  = '0;
                            miss_nxt  = '0;
                            fwd       = 1'b1;
                        end else begin
                            good_nxt = good + 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    pos_en = 1'b1;
                    fwd    = 1'b1;
                    if (at_zero) begin
                        if (is_sync) begin
                            miss_nxt = '0;
                        end else if (miss == MISS_LAST) begin
                            // Dropping this boundary byte keeps every output packet whole.
                            state_nxt = ST_HUNT;
                            miss_nxt  = '0;
                            pos_clr   = 1'b1;
                            fwd       = 1'b0;
                            lose      = 1'b1;
                        end else begin
                            miss_nxt = miss + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_HUNT;
                    good_nxt  = '0;
                    miss_nxt  = '0;
                    pos_clr   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_sop      <= 1'b0;
            out_eop      <= 1'b0;
            out_sync_err <= 1'b0;
            sync_loss    <= 1'b0;
            loss_count   <= '0;
            pkt_count    <= '0;
        end else begin
            out_valid    <= fwd;
            out_sop      <= fwd && at_zero;
            out_eop      <= fwd && at_last;
            out_sync_err <= fwd && at_zero && !is_sync;
            sync_loss    <= lose;
            if (fwd) begin
                out_data <= in_data;
            end
            if (lose && (loss_count != '1)) begin
                loss_count <= loss_count + 1'b1;
            end
            if (fwd && at_last) begin
                pkt_count <= pkt_count + 1'b1;
            end
        end
    end

    assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_ts_sync_detector.sv
module tb_ts_sync_detector;

    localparam int PLEN   = 188;
    localparam int LOCKN  = 3;
    localparam int UNLOCKN = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sop, out_eop, out_sync_err, locked, sync_loss;
    logic [15:0] loss_count;
    logic [31:0] pkt_count;

    ts_sync_detector #(
        .DATA_WIDTH (8),
        .PKT_LEN    (PLEN),
        .SYNC_BYTE  (8'h47),
        .LOCK_CNT   (LOCKN),
        .UNLOCK_CNT (UNLOCKN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_sync_err (out_sync_err),
        .locked       (locked),
        .sync_loss    (sync_loss),
        .loss_count   (loss_count),
        .pkt_count    (pkt_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // conf: number of consecutive correctly spaced syncs seen (0 = hunting,
    // LOCKN = locked). off: accepted bytes since the anchoring sync, mod PLEN.
    int          m_conf = 0, m_miss = 0, m_off = 0;
    logic        e_valid, e_sop, e_eop, e_err, e_loss;
    logic [7:0]  e_data;
    logic [15:0] e_losses;
    logic [31:0] e_pkts;

    task automatic model_reset();
        m_conf = 0; m_miss = 0; m_off = 0;
        e_valid = 0; e_sop = 0; e_eop = 0; e_err = 0; e_loss = 0;
        e_data = 0; e_losses = 0; e_pkts = 0;
    endtask

    task automatic model_emit(input logic [7:0] d, input int here, input bit s);
        e_valid = 1; e_data = d;
        e_sop = (here == 0);
        e_eop = (here == PLEN - 1);
        e_err = (here == 0) && !s;
        if (e_eop) e_pkts = e_pkts + 1;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        bit s;
        int here;
        e_valid = 0; e_sop = 0; e_eop = 0; e_err = 0; e_loss = 0;
        if (!v) return;
        s = (d == 8'h47);
        if (m_conf == 0) begin
            if (s) begin m_conf = 1; m_off = 1; end
            return;
        end
        here = m_off;
        m_off = (m_off + 1) % PLEN;
        if (m_conf < LOCKN) begin
            if (here == 0) m_conf = s ? m_conf + 1 : 0;
            if (m_conf == LOCKN) begin
                m_miss = 0;
                model_emit(d, here, s);
            end
        end else if (here == 0 && !s && m_miss + 1 == UNLOCKN) begin
            m_conf = 0; m_miss = 0; e_loss = 1;
            if (e_losses != 16'hFFFF) e_losses = e_losses + 1;
        end else begin
            if (here == 0) m_miss = s ? 0 : m_miss + 1;
            model_emit(d, here, s);
        end
    endtask

    // ---------------- observation of DUT (for literal pins) ----------------
    int         acc_count = 0, lock_at = -1, sop_cnt = 0, eop_cnt = 0, err_cnt = 0, loss_pulses = 0;
    logic       prev_locked = 0;
    logic [7:0] out_log[$];

    task automatic clear_obs();
        acc_count = 0; lock_at = -1; sop_cnt = 0; eop_cnt = 0; err_cnt = 0; loss_pulses = 0;
        out_log.delete();
    endtask

    // Per-cycle compare against the model, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else begin
            model_step(in_valid, in_data);
            if (in_valid) acc_count++;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("out_sop", 32'(out_sop), 32'(e_sop));
        chk("out_eop", 32'(out_eop), 32'(e_eop));
        chk("out_sync_err", 32'(out_sync_err), 32'(e_err));
        if (e_valid || !rst_n) chk("out_data", 32'(out_data), 32'(e_data));
        chk("locked", 32'(locked), 32'(m_conf == LOCKN));
        chk("sync_loss", 32'(sync_loss), 32'(e_loss));
        chk("loss_count", 32'(loss_count), 32'(e_losses));
        chk("pkt_count", pkt_count, e_pkts);
        if (out_valid) out_log.push_back(out_data);
        if (out_sop) sop_cnt++;
        if (out_eop) eop_cnt++;
        if (out_sync_err) err_cnt++;
        if (sync_loss) loss_pulses++;
        if (locked && !prev_locked && lock_at < 0) lock_at = acc_count - 1;
        prev_locked = locked;
    end

    // ---------------- stimulus ----------------
    function automatic logic [7:0] payload(input int i);
        return 8'(i % 64);   // never 0x47
    endfunction

    task automatic put(input logic [7:0] d, input int gap_pct);
        int g = 0;
        while (gap_pct > 0 && g < 3 && $urandom_range(0, 99) < gap_pct) begin
            @(negedge clk); in_valid = 1'b0; in_data = 8'hEE; g++;
        end
        @(negedge clk); in_valid = 1'b1; in_data = d;
    endtask

    task automatic send_pkt(input logic [7:0] s, input int gap_pct, input int nbytes);
        put(s, gap_pct);
        for (int i = 1; i < nbytes; i++) put(payload(i), gap_pct);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); in_valid = 1'b0; in_data = 8'h00;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        clear_obs();
    endtask

    logic [7:0] ref_log[$];

    initial begin
        // Reset state pinned by hand.
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_pkt_count", pkt_count, 32'd0);
        rst_n = 1'b1;
        clear_obs();

        // 1: five clean packets, no gaps.
        for (int p = 0; p < 5; p++) send_pkt(8'h47, 0, PLEN);
        idle(3);
        chk("s1_lock_at", 32'(lock_at), 32'd376);
        chk("s1_first_byte", 32'(out_log.size() > 0 ? out_log[0] : 8'hxx), 32'h47);
        chk("s1_sop_cnt", 32'(sop_cnt), 32'd3);
        chk("s1_eop_cnt", 32'(eop_cnt), 32'd3);
        chk("s1_pkt_count", pkt_count, 32'd3);
        chk("s1_bytes", 32'(out_log.size()), 32'd564);
        ref_log = out_log;

        // 2: same stream with ~30% gaps.
        do_reset();
        for (int p = 0; p < 5; p++) send_pkt(8'h47, 30, PLEN);
        idle(3);
        chk("s2_bytes", 32'(out_log.size()), 32'(ref_log.size()));
        begin
            int diff = 0;
            for (int i = 0; i < out_log.size() && i < ref_log.size(); i++)
                if (out_log[i] !== ref_log[i]) diff++;
            chk("s2_seq_diff", 32'(diff), 32'd0);
        end

        // 3: stray sync in noise before the real stream.
        do_reset();
        for (int i = 0; i < 50; i++) put(payload(i + 5), 0);
        put(8'h47, 0);
        for (int i = 0; i < 120; i++) put(payload(i + 9), 0);
        chk("s3_no_lock_yet", 32'(locked), 32'd0);
        for (int p = 0; p < 6; p++) send_pkt(8'h47, 0, PLEN);
        idle(3);
        chk("s3_pkt_count", pkt_count, 32'd3);
        chk("s3_first_byte", 32'(out_log.size() > 0 ? out_log[0] : 8'hxx), 32'h47);

        // 4: one corrupted sync while locked.
        do_reset();
        for (int p = 0; p < 3; p++) send_pkt(8'h47, 0, PLEN);
        send_pkt(8'h00, 0, PLEN);
        send_pkt(8'h47, 0, PLEN);
        send_pkt(8'h47, 0, PLEN);
        idle(3);
        chk("s4_err_cnt", 32'(err_cnt), 32'd1);
        chk("s4_locked", 32'(locked), 32'd1);
        chk("s4_loss_pulses", 32'(loss_pulses), 32'd0);
        chk("s4_pkt_count", pkt_count, 32'd4);

        // 5: three consecutive corrupted syncs -> loss.
        do_reset();
        for (int p = 0; p < 4; p++) send_pkt(8'h47, 0, PLEN);
        for (int p = 0; p < 3; p++) send_pkt(8'h00, 0, PLEN);
        idle(3);
        chk("s5_err_cnt", 32'(err_cnt), 32'd2);
        chk("s5_loss_pulses", 32'(loss_pulses), 32'd1);
        chk("s5_locked", 32'(locked), 32'd0);
        chk("s5_loss_count", 32'(loss_count), 32'd1);
        chk("s5_pkt_count", pkt_count, 32'd4);

        // 6: reset mid-packet while locked, then relock.
        do_reset();
        for (int p = 0; p < 3; p++) send_pkt(8'h47, 0, PLEN);
        send_pkt(8'h47, 0, 100);
        @(negedge clk); rst_n = 1'b0; in_valid = 1'b1; in_data = payload(100);
        @(negedge clk);
        chk("s6_rst_valid", 32'(out_valid), 32'd0);
        chk("s6_rst_locked", 32'(locked), 32'd0);
        chk("s6_rst_pkt_count", pkt_count, 32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        clear_obs();
        send_pkt(8'h47, 0, PLEN);
        send_pkt(8'h47, 0, PLEN);
        idle(2);
        chk("s6_not_relocked", 32'(locked), 32'd0);
        send_pkt(8'h47, 0, PLEN);
        idle(3);
        chk("s6_relocked", 32'(locked), 32'd1);
        chk("s6_pkt_count", pkt_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
